// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and helpers for the UART receive path.
// State encoding, parity config bit positions, parity function.
package item_pack;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF = 8;

  localparam int PARITY_EN_BIT = 1;
  localparam int PARITY_ODD_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_rx_state_e;

  // Expected parity bit: even -> ^data, odd -> ~^data.
  // Callers zero-extend narrower words, which leaves the xor unchanged.
  function automatic logic calc_parity(
    input logic [31:0] data,
    input logic odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Received-byte holding register handshake (valid/ready + flags).
// master = receiver side, slave = downstream consumer.
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic parity_err;
  logic frame_err;
  logic overrun_err;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun_err,
    input rx_ready
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input parity_err,
    input frame_err,
    input overrun_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_bit_timer.sv
// Per-bit cycle counter with sample and bit-end strobes.
// UART_RX_MAJORITY_EN: 3-sample vote, decision one cycle later.
module uart_rx_bit_timer
  import item_pack::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic rx_in,
  output logic sample_stb,
  output logic bit_end_stb,
  output logic bit_val
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int SAMP = CLKS_PER_BIT / 2 - 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Start detect is cycle 0, so the counter resumes at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CW'(1);
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end_stb = (cnt == LAST);

`ifdef UART_RX_MAJORITY_EN
  logic s_lo;
  logic s_mid;

  // Hold the two earlier votes; the third is the live line.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_lo <= 1'b0;
      s_mid <= 1'b0;
    end else begin
      if (cnt == CW'(SAMP - 1)) s_lo <= rx_in;
      if (cnt == CW'(SAMP)) s_mid <= rx_in;
    end
  end

  assign sample_stb = (cnt == CW'(SAMP + 1));
  assign bit_val = (s_lo & s_mid) |
                   (s_lo & rx_in) |
                   (s_mid & rx_in);
`else
  assign sample_stb = (cnt == CW'(SAMP));
  assign bit_val = rx_in;
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8N/8P + 2 stop, byte into valid/ready register.
// Optional majority voting via UART_RX_MAJORITY_EN.
module uart_rx_deserializer
  import item_pack::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic [1:0] parity_config,
  output logic busy,
  uart_rx_deserializer_if.master rx
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_rx_state_e state;
  uart_rx_state_e nxt;

  logic sample_stb;
  logic bit_end_stb;
  logic bit_val;

  logic prev_in;
  logic [1:0] cfg;
  logic [DATA_BITS-1:0] shift;
  logic [IW-1:0] bit_idx;
  logic parity_bad;
  logic stop_bad;

  logic start_det;
  logic take_data;
  logic step_idx;
  logic take_par;
  logic take_stop;
  logic done;

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .restart(start_det),
    .rx_in(rx_in),
    .sample_stb(sample_stb),
    .bit_end_stb(bit_end_stb),
    .bit_val(bit_val)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end

  // Next state; STOP2 leaves at its sample for back-to-back frames.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start_det) nxt = START;
      end
      START: begin
        if (sample_stb && bit_val) nxt = IDLE;
        else if (bit_end_stb) nxt = DATA;
      end
      DATA: begin
        if (bit_end_stb && bit_idx == LAST_IDX) begin
          if (cfg[PARITY_EN_BIT]) nxt = PARITY;
          else nxt = STOP1;
        end
      end
      PARITY: begin
        if (bit_end_stb) nxt = STOP1;
      end
      STOP1: begin
        if (bit_end_stb) nxt = STOP2;
      end
      STOP2: begin
        if (sample_stb) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Per-state strobes for the datapath.
  always_comb begin
    start_det = 1'b0;
    take_data = 1'b0;
    step_idx = 1'b0;
    take_par = 1'b0;
    take_stop = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: start_det = prev_in & ~rx_in;
      DATA: begin
        take_data = sample_stb;
        step_idx = bit_end_stb;
      end
      PARITY: take_par = sample_stb;
      STOP1: take_stop = sample_stb;
      STOP2: begin
        take_stop = sample_stb;
        done = sample_stb;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // Frame datapath: edge history, config latch, shift, error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_in <= 1'b0;
      cfg <= '0;
      shift <= '0;
      bit_idx <= '0;
      parity_bad <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      prev_in <= rx_in;
      if (start_det) begin
        cfg <= parity_config;
        bit_idx <= '0;
        parity_bad <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (take_data) shift[bit_idx] <= bit_val;
      if (step_idx) bit_idx <= bit_idx + 1'b1;
      if (take_par) begin
        parity_bad <= bit_val !=
          calc_parity(32'(shift), cfg[PARITY_ODD_BIT]);
      end
      if (take_stop && !bit_val) stop_bad <= 1'b1;
    end
  end

  // Holding register; a new frame overwrites an unaccepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx.rx_data <= '0;
      rx.rx_valid <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun_err <= 1'b0;
    end else if (done) begin
      rx.rx_data <= shift;
      rx.rx_valid <= 1'b1;
      rx.parity_err <= parity_bad;
      rx.frame_err <= stop_bad | ~bit_val;
      if (rx.rx_valid && !rx.rx_ready) begin
        rx.overrun_err <= 1'b1;
      end
    end else if (rx.rx_valid && rx.rx_ready) begin
      rx.rx_valid <= 1'b0;
    end
  end

endmodule
